priority_encoder_8_to_3: RTL and testbench

PRIORITY_ENCODER_8_TO_3 -- requirements
Module: priority_encoder_8_to_3

---
 rtl/priority_encoder_8_to_3.sv | 86 ++++++++
 tb/tb_priority_encoder_8_to_3.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/priority_encoder_8_to_3.sv
`default_nettype none
// ============================================================================
// Module      : priority_encoder_8_to_3
// Description : Sticky 8-request pending register with registered, handshaked
//               lowest-index-first encoding to a 3-bit index.
// Revision    : 1.0 - initial release
// ============================================================================
module priority_encoder_8_to_3 (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] in,
  input  logic       ready,
  output logic [2:0] out,
  output logic       valid,
  output logic [3:0] pend_cnt,
  output logic       overrun
);

  localparam logic [7:0] c_zero8 = 8'h00;

  logic [7:0] r_pend;
  logic [2:0] r_out;
  logic       r_valid;
  logic       r_overrun;

  logic       w_free;
  logic       w_load;
  logic [2:0] w_k;
  logic [7:0] w_load_mask;
  logic [7:0] w_cap;
  logic [7:0] w_pend_next;
  logic       w_overrun_next;
  logic [3:0] w_cnt;

  assign w_free = ~r_valid | ready;
  assign w_load = w_free & (r_pend != c_zero8);
  assign w_cap  = ena ? in : c_zero8;

  // Descending scan so the lowest set index wins.
  always_comb begin
    w_k = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (r_pend[i]) w_k = 3'(i);
    end
  end

  always_comb begin
    w_load_mask = c_zero8;
    if (w_load) w_load_mask[w_k] = 1'b1;
  end

  // A bit being loaded this edge may be re-requested without flagging overrun.
  assign w_pend_next    = (r_pend & ~w_load_mask) | w_cap;
  assign w_overrun_next = |(w_cap & r_pend & ~w_load_mask);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend    <= c_zero8;
      r_out     <= 3'd0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_pend    <= w_pend_next;
      r_overrun <= w_overrun_next;
      if (w_free) begin
        r_valid <= w_load;
        if (w_load) r_out <= w_k;
      end
    end
  end

  always_comb begin
    w_cnt = 4'd0;
    for (int i = 0; i < 8; i++) begin
      w_cnt = w_cnt + {3'd0, r_pend[i]};
    end
  end

  assign out      = r_out;
  assign valid    = r_valid;
  assign overrun  = r_overrun;
  assign pend_cnt = w_cnt;

endmodule
`default_nettype wire

// File: tb/tb_priority_encoder_8_to_3.sv
`default_nettype none
// ============================================================================
// Module      : tb_priority_encoder_8_to_3
// Description : Scoreboard bench for priority_encoder_8_to_3.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_priority_encoder_8_to_3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b0;
  logic [7:0] in  = 8'h00;
  logic       ready = 1'b0;
  logic [2:0] out;
  logic       valid;
  logic [3:0] pend_cnt;
  logic       overrun;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic       v;
    logic [2:0] o;
    logic [3:0] c;
    logic       ov;
  } exp_t;

  exp_t       eq[$];
  logic [2:0] xq[$];

  logic [7:0] m_pend  = 8'h00;
  logic       m_valid = 1'b0;
  logic [2:0] m_out   = 3'd0;
  logic       m_ov    = 1'b0;

  priority_encoder_8_to_3 dut (
    .clk(clk), .rst(rst), .ena(ena), .in(in), .ready(ready),
    .out(out), .valid(valid), .pend_cnt(pend_cnt), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: advances on each edge from the inputs the bench drove.
  always @(posedge clk) begin
    logic       free;
    logic [7:0] mask;
    logic [7:0] cap;
    exp_t       e;
    exp_t       g;
    if (!rst && valid && ready) begin
      if (xq.size() == 0) chk("xfer_unexpected", {29'd0, out}, 32'hFFFF_FFFF);
      else                chk("xfer_index", {29'd0, out}, {29'd0, xq.pop_front()});
    end
    if (rst) begin
      m_pend = 8'h00; m_valid = 1'b0; m_out = 3'd0; m_ov = 1'b0;
      xq.delete();
    end else begin
      free = !m_valid || ready;
      mask = 8'h00;
      cap  = ena ? in : 8'h00;
      if (free) begin
        if (m_pend != 8'h00) begin
          for (int i = 0; i < 8; i++) begin
            if (m_pend[i] && mask == 8'h00) begin
              mask  = 8'h01 << i;
              m_out = 3'(i);
            end
          end
          m_valid = 1'b1;
          xq.push_back(m_out);
        end else begin
          m_valid = 1'b0;
        end
      end
      m_ov   = |(cap & m_pend & ~mask);
      m_pend = (m_pend & ~mask) | cap;
    end
    e.v = m_valid; e.o = m_out; e.c = 4'($countones(m_pend)); e.ov = m_ov;
    eq.push_back(e);
    #1;
    g = eq.pop_front();
    chk("valid", {31'd0, valid}, {31'd0, g.v});
    if (g.v) chk("out", {29'd0, out}, {29'd0, g.o});
    chk("pend_cnt", {28'd0, pend_cnt}, {28'd0, g.c});
    chk("overrun", {31'd0, overrun}, {31'd0, g.ov});
  end

  task automatic cyc(input logic e, input logic [7:0] i, input logic r, input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      ena = e; in = i; ready = r;
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_out", {29'd0, out}, 32'd0);
    chk("rst_cnt", {28'd0, pend_cnt}, 32'd0);
    chk("rst_ovr", {31'd0, overrun}, 32'd0);
    rst = 1'b0;

    // idle
    cyc(1'b1, 8'h00, 1'b1, 5);
    // three requests drain in priority order 2, 5, 7
    cyc(1'b1, 8'hA4, 1'b1);
    cyc(1'b1, 8'h00, 1'b1, 6);
    // held output under back-pressure
    cyc(1'b1, 8'h08, 1'b0);
    cyc(1'b1, 8'h00, 1'b0, 10);
    cyc(1'b1, 8'h00, 1'b1, 3);
    // overrun on pending bit, none on the load edge of that bit
    cyc(1'b1, 8'h11, 1'b0);
    cyc(1'b1, 8'h00, 1'b0, 2);
    cyc(1'b1, 8'h10, 1'b0);
    cyc(1'b1, 8'h00, 1'b0, 2);
    cyc(1'b1, 8'h10, 1'b1);
    cyc(1'b1, 8'h00, 1'b1, 4);
    // ena=0 masks input but not draining
    cyc(1'b1, 8'h03, 1'b0);
    cyc(1'b0, 8'hFF, 1'b0, 2);
    cyc(1'b0, 8'hFF, 1'b1, 4);
    cyc(1'b1, 8'h00, 1'b1, 2);
    // asynchronous reset mid-cycle with pend=F0 and valid=1
    cyc(1'b1, 8'hF1, 1'b0);
    cyc(1'b1, 8'h00, 1'b0, 2);
    @(posedge clk);
    #3;
    ena = 1'b0; in = 8'h00; ready = 1'b1;
    rst = 1'b1;
    #1;
    chk("arst_valid", {31'd0, valid}, 32'd0);
    chk("arst_out", {29'd0, out}, 32'd0);
    chk("arst_cnt", {28'd0, pend_cnt}, 32'd0);
    chk("arst_ovr", {31'd0, overrun}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc(1'b1, 8'h00, 1'b1, 4);
    // random traffic
    for (int k = 0; k < 300; k++) begin
      cyc(1'($urandom_range(0, 3) != 0),
          ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00,
          1'($urandom_range(0, 2) != 0));
    end
    cyc(1'b0, 8'h00, 1'b1, 12);
    @(negedge clk);
    chk("drained_cnt", {28'd0, pend_cnt}, 32'd0);
    chk("drained_valid", {31'd0, valid}, 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
